// File: rtl/uart_tx_frame_param.sv
// Parametrised UART transmitter: start bit, DATA_BITS data bits LSB first, optional
// parity, STOP_BITS stop bits, each bit held CLKS_PER_BIT clocks. All outputs registered.
module uart_tx_frame_param #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 ipclk,
  input  logic                 iprst_n,
  input  logic [DATA_BITS-1:0] datain,
  input  logic                 valid,
  output logic                 ready,
  output logic                 tx,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int IW = $clog2(DATA_BITS + 1);

  localparam logic [CW-1:0] CNT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  if (DATA_BITS < 5 || DATA_BITS > 9 || CLKS_PER_BIT < 2 ||
      PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_param_check
    $error("uart_tx_frame_param: illegal parameter combination");
  end

  // Odd parity makes the total count of ones (data + parity) odd.
  function automatic logic parity_bit(input logic [DATA_BITS-1:0] d);
    logic p;
    if (PARITY == 1) begin
      p = ~^d;
    end else begin
      p = ^d;
    end
    return p;
  endfunction

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 par_q, par_d;
  logic                 tx_q, tx_d;
  logic                 ready_q, busy_q, done_q;
  logic                 bit_end_s, frame_end_s;
  logic [DATA_BITS-1:0] shifted_s;

  assign bit_end_s   = (cnt_q == CNT_LAST);
  assign frame_end_s = (state_q == S_STOP) && bit_end_s && (idx_q == STOP_LAST);
  assign shifted_s   = data_q >> idx_q;

  // Frame sequencer: state, baud counter, bit index and latched word.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    data_d  = data_q;
    par_d   = par_q;
    case (state_q)
      S_IDLE: begin
        if (valid && ready_q) begin
          state_d = S_START;
          cnt_d   = '0;
          idx_d   = '0;
          data_d  = datain;
          par_d   = parity_bit(datain);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_DATA;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DATA: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (PARITY != 0) ? S_PARITY : S_STOP;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_PARITY: begin
        if (bit_end_s) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = S_STOP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_STOP: begin
        if (bit_end_s) begin
          cnt_d = '0;
          if (idx_q == STOP_LAST) begin
            idx_d   = '0;
            state_d = S_IDLE;
          end else begin
            idx_d = idx_q + IW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase
  end

  // Line level follows the current state, so tx trails the state register by one clock.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      S_IDLE:   tx_d = 1'b1;
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shifted_s[0];
      S_PARITY: tx_d = par_q;
      S_STOP:   tx_d = 1'b1;
      default:  tx_d = 1'b1;
    endcase
  end

  // State and output registers; reset forces the line to mark immediately.
  always_ff @(posedge ipclk or negedge iprst_n) begin
    if (!iprst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      data_q  <= '0;
      par_q   <= 1'b0;
      tx_q    <= 1'b1;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      data_q  <= data_d;
      par_q   <= par_d;
      tx_q    <= tx_d;
      ready_q <= (state_d == S_IDLE);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= frame_end_s;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_uart_tx_frame_param.sv
// Scoreboard bench for uart_tx_frame_param: four instances (8N1, 8E1, 8O1, 7N2) at
// 4 clocks per bit; expected frames are queued at handshake and checked by a line monitor.
module tb_uart_tx_frame_param;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] din [4];
  logic [3:0] valid_s = 4'h0;
  logic [3:0] ready_s, tx_s, busy_s, done_s;

  int cyc = 0;
  int n_checks = 0;
  int n_fail = 0;
  bit allow_unexp = 1'b0;
  bit in_frame = 1'b0;

  typedef struct {
    int          id;
    int          nbits;
    logic [15:0] bits;
    int          hs;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_frame_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .ipclk(clk), .iprst_n(rst_n), .datain(din[0][7:0]), .valid(valid_s[0]),
    .ready(ready_s[0]), .tx(tx_s[0]), .busy(busy_s[0]), .done(done_s[0]));

  uart_tx_frame_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .ipclk(clk), .iprst_n(rst_n), .datain(din[1][7:0]), .valid(valid_s[1]),
    .ready(ready_s[1]), .tx(tx_s[1]), .busy(busy_s[1]), .done(done_s[1]));

  uart_tx_frame_param #(.DATA_BITS(8), .CLKS_PER_BIT(CPB), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .ipclk(clk), .iprst_n(rst_n), .datain(din[2][7:0]), .valid(valid_s[2]),
    .ready(ready_s[2]), .tx(tx_s[2]), .busy(busy_s[2]), .done(done_s[2]));

  uart_tx_frame_param #(.DATA_BITS(7), .CLKS_PER_BIT(CPB), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .ipclk(clk), .iprst_n(rst_n), .datain(din[3][6:0]), .valid(valid_s[3]),
    .ready(ready_s[3]), .tx(tx_s[3]), .busy(busy_s[3]), .done(done_s[3]));

  task automatic chk(input string name, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp_v, $time);
    end
  endtask

  // Monitor: a frame starts when the queued instance pulls its line low. Every clock of
  // the frame is sampled; done must be high only in the final frame clock, when busy
  // has already dropped and ready has returned.
  initial begin : monitor
    exp_t e;
    int   nclk;
    int   good;
    bit   done_bad, busy_bad, rdy_bad;
    forever begin
      @(negedge clk);
      if (!rst_n) continue;
      if (sb.size() != 0) begin
        e = sb[0];
        if (tx_s[e.id] == 1'b0) begin
          in_frame = 1'b1;
          e = sb.pop_front();
          chk($sformatf("u%0d_start_latency", e.id), cyc - e.hs, 2);
          nclk = e.nbits * CPB;
          good = 0;
          done_bad = 1'b0;
          busy_bad = 1'b0;
          rdy_bad  = 1'b0;
          for (int k = 0; k < nclk; k++) begin
            if (k != 0) @(negedge clk);
            if (tx_s[e.id] === e.bits[k / CPB]) good++;
            if (done_s[e.id] !== ((k == nclk - 1) ? 1'b1 : 1'b0)) done_bad = 1'b1;
            if (busy_s[e.id] !== ((k <  nclk - 1) ? 1'b1 : 1'b0)) busy_bad = 1'b1;
            if (ready_s[e.id] !== ((k == nclk - 1) ? 1'b1 : 1'b0)) rdy_bad = 1'b1;
            if ((k % CPB) == CPB - 1) begin
              chk($sformatf("u%0d_bit%0d_clocks_ok", e.id, k / CPB), good, CPB);
              good = 0;
            end
          end
          chk($sformatf("u%0d_done_pulse_bad", e.id), int'(done_bad), 0);
          chk($sformatf("u%0d_busy_bad", e.id), int'(busy_bad), 0);
          chk($sformatf("u%0d_ready_bad", e.id), int'(rdy_bad), 0);
          in_frame = 1'b0;
        end
      end else if (!allow_unexp && tx_s !== 4'hF) begin
        chk("idle_line_mark", int'(tx_s), 15);
      end
    end
  end

  // Offer a word; push the expected frame in the clock whose posedge will accept it.
  task automatic send(input int id, input logic [8:0] data, input logic [15:0] frame,
                      input int nbits, input bit expect_frame, input bit keep_valid,
                      output int hs);
    int n = 0;
    din[id] = data;
    valid_s[id] = 1'b1;
    while (!ready_s[id] && n < 500) begin
      @(negedge clk);
      n++;
    end
    hs = cyc;
    if (n >= 500) begin
      chk($sformatf("u%0d_ready_timeout", id), 1, 0);
    end else if (expect_frame) begin
      sb.push_back('{id: id, nbits: nbits, bits: frame, hs: cyc});
    end
    @(negedge clk);
    if (!keep_valid) valid_s[id] = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || in_frame) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) chk("drain_timeout", 1, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int hs0, hs1, hs_dummy;
    for (int i = 0; i < 4; i++) din[i] = 9'h000;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset state on every instance
    chk("reset_tx",    int'(tx_s),    15);
    chk("reset_ready", int'(ready_s), 15);
    chk("reset_busy",  int'(busy_s),  0);
    chk("reset_done",  int'(done_s),  0);

    // 8N1, 0xA5: line bits 0,1,0,1,0,0,1,0,1,1
    send(0, 9'h0A5, {6'h00, 1'b1, 8'hA5, 1'b0}, 10, 1'b1, 1'b0, hs_dummy);
    drain();

    // Parity: 0x07 -> even 1 / odd 0; 0xFF -> even 0 / odd 1; 0x00 -> even 0 / odd 1
    send(1, 9'h007, {5'h00, 1'b1, 1'b1, 8'h07, 1'b0}, 11, 1'b1, 1'b0, hs_dummy);
    drain();
    send(2, 9'h007, {5'h00, 1'b1, 1'b0, 8'h07, 1'b0}, 11, 1'b1, 1'b0, hs_dummy);
    drain();
    send(1, 9'h0FF, {5'h00, 1'b1, 1'b0, 8'hFF, 1'b0}, 11, 1'b1, 1'b0, hs_dummy);
    drain();
    send(2, 9'h0FF, {5'h00, 1'b1, 1'b1, 8'hFF, 1'b0}, 11, 1'b1, 1'b0, hs_dummy);
    drain();
    send(2, 9'h000, {5'h00, 1'b1, 1'b1, 8'h00, 1'b0}, 11, 1'b1, 1'b0, hs_dummy);
    drain();

    // 7 data bits, 2 stop bits
    send(3, 9'h07F, {6'h00, 2'b11, 7'h7F, 1'b0}, 10, 1'b1, 1'b0, hs_dummy);
    drain();
    send(3, 9'h000, {6'h00, 2'b11, 7'h00, 1'b0}, 10, 1'b1, 1'b0, hs_dummy);
    drain();

    // Back-to-back with valid held, then a stray valid pulse mid-frame
    send(0, 9'h055, {6'h00, 1'b1, 8'h55, 1'b0}, 10, 1'b1, 1'b1, hs0);
    send(0, 9'h0AA, {6'h00, 1'b1, 8'hAA, 1'b0}, 10, 1'b1, 1'b0, hs1);
    chk("b2b_handshake_period", hs1 - hs0, 41);
    repeat (10) @(negedge clk);
    din[0] = 9'h0FF;
    valid_s[0] = 1'b1;
    @(negedge clk);
    valid_s[0] = 1'b0;
    drain();

    // Reset during data bit 3 aborts the frame at once
    allow_unexp = 1'b1;
    send(0, 9'h0F0, 16'h0000, 10, 1'b0, 1'b0, hs_dummy);
    repeat (18) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midframe_rst_tx",    int'(tx_s[0]),    1);
    chk("midframe_rst_ready", int'(ready_s[0]), 1);
    chk("midframe_rst_busy",  int'(busy_s[0]),  0);
    chk("midframe_rst_done",  int'(done_s[0]),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    allow_unexp = 1'b0;
    send(0, 9'h03C, {6'h00, 1'b1, 8'h3C, 1'b0}, 10, 1'b1, 1'b0, hs_dummy);
    drain();

    // datain churns every clock during the frame; the handshake word must go out
    send(0, 9'h096, {6'h00, 1'b1, 8'h96, 1'b0}, 10, 1'b1, 1'b0, hs_dummy);
    for (int i = 0; i < 45; i++) begin
      din[0] = din[0] + 9'd37;
      @(negedge clk);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
